// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter: FSM encoding, PSEL
// geometry and the round-robin pick used by apb_rr_arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam int PSEL_WIDTH = 16;
    localparam int SLOT_BITS  = 4;
    localparam int MAX_REQ    = 8;

    // First set bit of valid searching upward from last+1, wrapping at num_req.
    // Returns last when nothing is valid; callers qualify with any-valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         last,
                                           input int unsigned        num_req);
        logic [2:0]  pick;
        int unsigned idx;
        pick = last;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int unsigned i = MAX_REQ; i >= 1; i--) begin
            if (i <= num_req) begin
                idx = 32'(last) + i;
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end
                if (valid[idx[2:0]]) begin
                    pick = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: combinational grant index from the request mask.
// Latency: pick is same-cycle; last_grant advances on the update strobe.
// Backpressure: none; the caller decides when a grant is consumed.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               update,
    input  logic [IDX_W-1:0]   update_idx,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    logic [IDX_W-1:0]   last_grant;
    logic [MAX_REQ-1:0] valid_pad;
    logic [2:0]         pick;

    always_comb begin
        valid_pad              = '0;
        valid_pad[NUM_REQ-1:0] = valid;
        pick                   = rr_pick(valid_pad, 3'(last_grant), NUM_REQ);
        grant_idx              = IDX_W'(pick);
        any_valid              = |valid;
    end

    // Parking on the top index makes requester 0 the first winner after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (update) begin
            last_grant <= update_idx;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB3 master port among NUM_REQ requesters with round-robin grant.
// Latency: 3 cycles minimum from REQ_VALID to REQ_DONE, plus slave wait states.
// Backpressure: requesters hold REQ_VALID until REQ_DONE; PREADY stalls ACCESS.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int SEL_LSB        = 24,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TPD            = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETN,
    input  logic [NUM_REQ-1:0]      REQ_VALID,
    input  logic [NUM_REQ-1:0]      REQ_WRITE,
    input  logic [NUM_REQ*32-1:0]   REQ_ADDR,
    input  logic [NUM_REQ*32-1:0]   REQ_WDATA,
    output logic [NUM_REQ-1:0]      REQ_DONE,
    output logic                    REQ_ERR,
    output logic [31:0]             REQ_RDATA,
    output logic [31:0]             PADDR,
    output logic [PSEL_WIDTH-1:0]   PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [31:0]             PWDATA,
    input  logic [31:0]             PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    output logic                    TIMEOUT_IRQ
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    apb_state_t state_q, state_nxt;

    logic [IDX_W-1:0]      grant_idx, grant_q;
    logic                  any_valid;
    logic [NUM_REQ-1:0]    arb_valid;
    logic [31:0]           win_addr, win_wdata;
    logic                  win_write;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic                  do_grant, do_complete, do_timeout;

    logic [31:0]           paddr_q, pwdata_q, rdata_q;
    logic [PSEL_WIDTH-1:0] psel_q;
    logic                  penable_q, pwrite_q, err_q, irq_q;
    logic [NUM_REQ-1:0]    done_q;

    // The finishing requester still shows VALID during its DONE cycle; it sits
    // that cycle out so any other pending requester wins the next slot.
    assign arb_valid = REQ_VALID & ~done_q;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk        (PCLK),
        .rst_n      (PRESETN),
        .valid      (arb_valid),
        .update     (do_complete),
        .update_idx (grant_q),
        .grant_idx  (grant_idx),
        .any_valid  (any_valid)
    );

    always_comb begin
        win_addr  = REQ_ADDR[32*int'(grant_idx) +: 32];
        win_wdata = REQ_WDATA[32*int'(grant_idx) +: 32];
        win_write = REQ_WRITE[grant_idx];
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        do_grant    = 1'b0;
        do_complete = 1'b0;
        do_timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    do_grant  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_nxt   = '0;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    do_complete = 1'b1;
                    state_nxt   = ST_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    do_complete = 1'b1;
                    do_timeout  = 1'b1;
                    state_nxt   = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt_q     <= '0;
            grant_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            if (do_grant) begin
                grant_q  <= grant_idx;
                paddr_q  <= win_addr;
                pwdata_q <= win_wdata;
                pwrite_q <= win_write;
                psel_q   <= PSEL_WIDTH'(1) << win_addr[SEL_LSB +: SLOT_BITS];
            end
            if (state_q == ST_SETUP) begin
                penable_q <= 1'b1;
            end
            if (do_complete) begin
                psel_q          <= '0;
                penable_q       <= 1'b0;
                done_q[grant_q] <= 1'b1;
                err_q           <= do_timeout | PSLVERR;
                rdata_q         <= (do_timeout || pwrite_q) ? 32'd0 : PRDATA;
                if (do_timeout) begin
                    irq_q <= 1'b1;
                end
            end
        end
    end

    // TPD is a simulation-only delay; synthesised outputs come straight from flops.
    if (TPD >= 0) begin : g_out
        assign PADDR       = paddr_q;
        assign PSEL        = psel_q;
        assign PENABLE     = penable_q;
        assign PWRITE      = pwrite_q;
        assign PWDATA      = pwdata_q;
        assign REQ_DONE    = done_q;
        assign REQ_ERR     = err_q;
        assign REQ_RDATA   = rdata_q;
        assign TIMEOUT_IRQ = irq_q;
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed vector table, reset/contention
// sequences and a randomized run scored against a round-robin reference model.
module tb_apb_master_arbiter;

    localparam int NR = 4;
    localparam int TO = 8;

    logic            PCLK;
    logic            PRESETN;
    logic [NR-1:0]   REQ_VALID, REQ_WRITE, REQ_DONE;
    logic [NR*32-1:0] REQ_ADDR, REQ_WDATA;
    logic            REQ_ERR;
    logic [31:0]     REQ_RDATA, PADDR, PWDATA, PRDATA;
    logic [15:0]     PSEL;
    logic            PENABLE, PWRITE, PREADY, PSLVERR, TIMEOUT_IRQ;

    int errors = 0;
    int checks = 0;

    apb_master_arbiter #(
        .NUM_REQ        (NR),
        .SEL_LSB        (24),
        .TIMEOUT_CYCLES (TO),
        .TPD            (1)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .REQ_VALID   (REQ_VALID),
        .REQ_WRITE   (REQ_WRITE),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .REQ_DONE    (REQ_DONE),
        .REQ_ERR     (REQ_ERR),
        .REQ_RDATA   (REQ_RDATA),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .TIMEOUT_IRQ (TIMEOUT_IRQ)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int          req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          wait_n;   // ACCESS cycle index where PREADY rises (>=TO never)
        logic [15:0] psel;
        int          lat;      // cycles from request to REQ_DONE
        logic [31:0] rdata;
        logic        err;
        logic        irq;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESETN   = 1'b0;
        REQ_VALID = '0;
        REQ_WRITE = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETN = 1'b1;
    endtask

    // Reference arbitration rule: first pending requester after the last winner.
    function automatic int rr_model(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic run_vec(input vec_t v, input int n);
        int lat;
        int bad;
        lat = -1;
        bad = 0;
        REQ_VALID[v.req]          = 1'b1;
        REQ_WRITE[v.req]          = v.wr;
        REQ_ADDR[32*v.req +: 32]  = v.addr;
        REQ_WDATA[32*v.req +: 32] = v.wdata;
        PRDATA  = v.prdata;
        PSLVERR = v.slverr;
        PREADY  = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            step();
            if (REQ_DONE != 0) begin
                lat = c;
                chk($sformatf("v%0d_done", n), 32'(REQ_DONE), 32'(1) << v.req);
                chk($sformatf("v%0d_rdata", n), REQ_RDATA, v.rdata);
                chk($sformatf("v%0d_err", n), 32'(REQ_ERR), 32'(v.err));
                chk($sformatf("v%0d_irq", n), 32'(TIMEOUT_IRQ), 32'(v.irq));
                chk($sformatf("v%0d_idle_psel", n), {16'd0, PSEL} | 32'(PENABLE), 32'd0);
            end else begin
                if (PSEL !== v.psel || PADDR !== v.addr || PWRITE !== v.wr ||
                    (v.wr && PWDATA !== v.wdata)) bad++;
                if (PENABLE !== (c >= 2)) bad++;
                PREADY = (c - 2 == v.wait_n);
            end
        end
        chk($sformatf("v%0d_latency", n), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_apb_stable", n), 32'(bad), 32'd0);
        REQ_VALID[v.req] = 1'b0;
        PREADY = 1'b0;
        step();
    endtask

    logic [NR-1:0] pending, prev_valid;
    logic [31:0]   addr_m[NR];
    logic [31:0]   wd_m[NR];
    logic          wr_m[NR];
    int            rereq_at[NR];

    initial begin
        int last_m, got, prev_d, exp_k, acc_n, wait_n, exp_done_cyc, n_done;
        logic in_flight, to_m, irq_m, exp_err;
        logic [31:0] exp_rdata;

        vecs[0] = '{0, 1'b1, 32'h0300_0010, 32'hA5A5_0001, 32'h0,         1'b0, 0,  16'h0008, 3,  32'h0,         1'b0, 1'b0};
        vecs[1] = '{2, 1'b0, 32'h0100_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 4,  16'h0002, 7,  32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{1, 1'b1, 32'h0F00_1234, 32'h1111_2222, 32'h0,         1'b1, 0,  16'h8000, 3,  32'h0,         1'b1, 1'b0};
        vecs[3] = '{3, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b1, 2,  16'h0001, 5,  32'h1234_5678, 1'b1, 1'b0};
        vecs[4] = '{1, 1'b0, 32'h0AFF_FFFC, 32'h0,         32'hCAFE_F00D, 1'b0, 7,  16'h0400, 10, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[5] = '{0, 1'b0, 32'h0500_0000, 32'h0,         32'h5555_AAAA, 1'b0, 99, 16'h0020, 10, 32'h0,         1'b1, 1'b1};
        vecs[6] = '{3, 1'b1, 32'h0C00_0008, 32'h7777_0000, 32'hFFFF_FFFF, 1'b0, 1,  16'h1000, 4,  32'h0,         1'b0, 1'b1};

        // Reset state
        PRESETN = 1'b0;
        REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #2;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_done", 32'(REQ_DONE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_irq_err", {30'd0, TIMEOUT_IRQ, REQ_ERR}, 32'd0);
        do_reset();
        step();

        for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

        // Reset in the middle of ACCESS wait states
        REQ_VALID[3] = 1'b1; REQ_WRITE[3] = 1'b0; REQ_ADDR[96 +: 32] = 32'h0200_0000;
        PREADY = 1'b0;
        repeat (4) step();
        chk("mid_penable_before", 32'(PENABLE), 32'd1);
        #3 PRESETN = 1'b0;
        #1;
        chk("mid_rst_psel", 32'(PSEL), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_done", 32'(REQ_DONE), 32'd0);
        chk("mid_rst_irq", 32'(TIMEOUT_IRQ), 32'd0);
        REQ_VALID = '0;
        step();
        PRESETN = 1'b1;

        // Contention: all requesters held valid, PREADY tied high
        for (int i = 0; i < NR; i++) begin
            REQ_WRITE[i] = 1'b1;
            REQ_ADDR[32*i +: 32]  = {4'h0, 4'(i + 1), 24'h000100};
            REQ_WDATA[32*i +: 32] = 32'(i);
        end
        REQ_VALID = '1; PREADY = 1'b1; PSLVERR = 1'b0;
        last_m = NR - 1; got = 0; prev_d = 0;
        for (int c = 1; c <= 60 && got < 6; c++) begin
            step();
            if (REQ_DONE != 0) begin
                exp_k = rr_model('1, last_m);
                chk($sformatf("cont_grant%0d", got), 32'(REQ_DONE), 32'(1) << exp_k);
                if (got == 0) chk("cont_first_lat", 32'(c), 32'd3);
                else chk($sformatf("cont_gap%0d", got), 32'(c - prev_d), 32'd3);
                prev_d = c; last_m = exp_k; got++;
            end
        end
        chk("cont_count", 32'(got), 32'd6);
        REQ_VALID = '0; PREADY = 1'b0;
        step(); step();

        // Randomized traffic against the reference model
        do_reset();
        last_m = NR - 1; irq_m = 1'b0; in_flight = 1'b0; n_done = 0;
        prev_valid = '0; pending = '0;
        exp_k = 0; acc_n = 0; wait_n = 0; exp_done_cyc = 0; to_m = 1'b0;
        exp_err = 1'b0; exp_rdata = '0;
        for (int i = 0; i < NR; i++) rereq_at[i] = 0;
        for (int cyc = 1; cyc <= 700; cyc++) begin
            step();
            if (in_flight && cyc == exp_done_cyc) begin
                irq_m = irq_m | to_m;
                chk("r_done", 32'(REQ_DONE), 32'(1) << exp_k);
                chk("r_err", 32'(REQ_ERR), 32'(exp_err));
                chk("r_rdata", REQ_RDATA, exp_rdata);
                chk("r_irq", 32'(TIMEOUT_IRQ), 32'(irq_m));
                REQ_VALID[exp_k] = 1'b0;
                pending[exp_k] = 1'b0;
                rereq_at[exp_k] = cyc + int'($urandom_range(1, 3));
                last_m = exp_k; in_flight = 1'b0; n_done++;
            end else if (REQ_DONE != 0) begin
                chk("r_spurious_done", 32'(REQ_DONE), 32'd0);
            end
            if (!in_flight && PSEL != 0) begin
                exp_k = rr_model(prev_valid, last_m);
                if (exp_k < 0) begin
                    chk("r_grant_without_req", 32'(PSEL), 32'd0);
                end else begin
                    chk("r_paddr", PADDR, addr_m[exp_k]);
                    chk("r_psel", 32'(PSEL), 32'(1) << addr_m[exp_k][27:24]);
                    chk("r_pwrite", 32'(PWRITE), 32'(wr_m[exp_k]));
                    if (wr_m[exp_k]) chk("r_pwdata", PWDATA, wd_m[exp_k]);
                    in_flight = 1'b1; acc_n = 0;
                    wait_n = int'($urandom_range(0, 10));
                    to_m = (wait_n >= TO);
                    exp_done_cyc = cyc + 1 + (to_m ? TO : wait_n + 1);
                    exp_err = 1'b1; exp_rdata = '0;
                end
            end
            if (in_flight && PSEL != 0 && PENABLE) begin
                PREADY = (acc_n == wait_n);
                if (PREADY) begin
                    PRDATA = $urandom;
                    PSLVERR = 1'($urandom_range(0, 1));
                    exp_err = PSLVERR;
                    exp_rdata = wr_m[exp_k] ? 32'd0 : PRDATA;
                end
                acc_n++;
            end else begin
                PREADY = 1'b0;
            end
            for (int i = 0; i < NR; i++) begin
                if (!pending[i] && cyc >= rereq_at[i] && cyc < 640 && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    addr_m[i] = $urandom;
                    wd_m[i] = $urandom;
                    wr_m[i] = 1'($urandom_range(0, 1));
                    REQ_ADDR[32*i +: 32] = addr_m[i];
                    REQ_WDATA[32*i +: 32] = wd_m[i];
                    REQ_WRITE[i] = wr_m[i];
                    REQ_VALID[i] = 1'b1;
                end
            end
            prev_valid = REQ_VALID;
        end
        chk("r_drained", 32'(in_flight), 32'd0);
        chk("r_enough_transfers", 32'(n_done >= 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port among NUM_REQ on-chip requesters. Requesters include the BFM command path, the boot-strap loader and the debug path.
- Uses round-robin arbitration, a full APB3 SETUP/ACCESS sequence and one-hot PSEL decode over 16 slave slots.
- A stalled slave cannot hang the bus: an optional PREADY timeout force-completes the transfer.
- Sits between the subsystem's internal masters and the APB slaves (CoreUARTapb, GPIO, timers).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SEL_LSB, 24, lowest PADDR bit of the 4-bit slot-select field PADDR[SEL_LSB+3:SEL_LSB].
- TIMEOUT_CYCLES, 256, ACCESS cycles allowed before forced completion; 0 disables the timeout.
- TPD, 1, output delay used in simulation only (ns).

Ports:
- PCLK  in  1  APB clock; the only clock in the block.
- PRESETN  in  1  asynchronous active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester request.
- REQ_WRITE  in  NUM_REQ  1 = write, 0 = read.
- REQ_ADDR  in  NUM_REQ*32  flattened; requester i occupies bits [32i+31:32i].
- REQ_WDATA  in  NUM_REQ*32  flattened write data.
- REQ_DONE  out  NUM_REQ  one-cycle completion pulse.
- REQ_ERR  out  1  error status of the completing transfer; valid with REQ_DONE.
- REQ_RDATA  out  32  read data; valid with REQ_DONE.
- PADDR  out  32  APB address.
- PSEL  out  16  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.
- TIMEOUT_IRQ  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync release to PCLK):
  - State IDLE; all outputs 0.
  - Round-robin pointer set so requester 0 has the highest priority first.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - If any REQ_VALID is set, grant the first set bit searching from last_grant+1 modulo NUM_REQ.
  - Latch the winner's ADDR, WDATA and WRITE into PADDR/PWDATA/PWRITE.
  - Drive PSEL[PADDR[SEL_LSB+3:SEL_LSB]]=1, PENABLE=0, then go to SETUP.
  - Arbitration is combinational; the outputs are registered. PSEL is therefore high in the cycle after REQ_VALID is first seen.
- SETUP: set PENABLE=1 and go to ACCESS unconditionally.
- ACCESS, cycle counter starts at 0:
  - PREADY=1: register REQ_RDATA=PRDATA (reads only; writes return 0) and REQ_ERR=PSLVERR. Pulse REQ_DONE[grant], clear PSEL/PENABLE, update last_grant and go to IDLE.
  - PREADY=0 and counter = TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0): complete as above with REQ_ERR=1 and REQ_RDATA=0, set TIMEOUT_IRQ, go to IDLE.
  - Otherwise increment the counter and hold all APB outputs stable.
- Completion timing: REQ_DONE and REQ_RDATA/REQ_ERR are high in the cycle after the PREADY-high edge.
- Minimum transfer: 3 cycles (SETUP, ACCESS, IDLE). There is always one IDLE cycle between transfers.
- Requester rules:
  - REQ_VALID and all request fields must be held until the REQ_DONE pulse.
  - Deasserting REQ_VALID after grant does not abort the transfer; REQ_DONE is still pulsed.
  - Request fields are sampled only at grant.
- A requester may re-request in the cycle after its REQ_DONE. It then loses to any other pending requester (fairness).
- All address bits pass to PADDR unmodified. Exactly one PSEL bit is high from SETUP through ACCESS.
- PRESETN asserted mid-transfer: all outputs drop to 0 immediately, no REQ_DONE is issued, and the request is lost.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Package apb_arb_pkg holds:
  - state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2);
  - PSEL_WIDTH=16 and SLOT_BITS=4;
  - a function rr_pick(valid, last) returning the grant index.
- One natural sub-module: apb_rr_arbiter, a parameterised round-robin picker holding last_grant and producing a grant index and any_valid.
- The FSM, latch registers and timeout counter stay in the top level.

Test Plan:
- Single write: req0 writes ADDR=0x0300_0010, WDATA=0xA5A5_0001, PREADY tied 1.
  Required: PSEL=0x0008 in SETUP; PENABLE high for 1 cycle; REQ_DONE[0] pulses 3 cycles after request; REQ_ERR=0.
- Read with 4 wait states: req2 reads 0x0100_0000, PRDATA=0xDEAD_BEEF, PREADY high on the 5th ACCESS cycle.
  Required: PADDR/PWRITE stable throughout; REQ_DONE[2] pulses once; REQ_RDATA=0xDEAD_BEEF.
- Contention: all four requesters assert VALID in the same cycle out of reset and re-request immediately after each DONE.
  Required: grant order 0,1,2,3,0,1 with no back-to-back grant to the same requester.
- Slave error: PSLVERR=1 with PREADY=1 on req1's write.
  Required: REQ_ERR=1 with REQ_DONE[1]; TIMEOUT_IRQ stays 0.
- Timeout: TIMEOUT_CYCLES=8, PREADY held 0.
  Required: forced completion after 8 ACCESS cycles; REQ_ERR=1, REQ_RDATA=0, TIMEOUT_IRQ=1; the next request proceeds normally.
- Reset mid-ACCESS: assert PRESETN low during wait states.
  Required: PSEL/PENABLE/REQ_DONE go to 0 asynchronously; after release, the first grant goes to requester 0.
